// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: shares the single cache_ctrl user port between two
// requesters (0 = AHB SRAM bridge, 1 = DMA/SD loader). One transaction is
// in flight at a time: IDLE -> ISSUE -> WAIT -> DONE, with a watchdog on
// the ISSUE phase in case the cache never raises busy.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin on ties;
// otherwise requester 0 always wins ties.
module cache_port_arbiter #(
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            rq_valid,
  input  logic [1:0]            rq_we,
  input  logic [W_ADDR-1:0]     rq_addr0,
  input  logic [W_ADDR-1:0]     rq_addr1,
  input  logic [W_DATA-1:0]     rq_wdata0,
  input  logic [W_DATA-1:0]     rq_wdata1,
  input  logic [W_DATA/8-1:0]   rq_mask0,
  input  logic [W_DATA/8-1:0]   rq_mask1,
  output logic [1:0]            rq_ready,
  output logic [1:0]            rq_done,
  output logic                  rq_err,
  output logic [W_DATA-1:0]     rq_rdata,
  output logic                  d_rd_en,
  output logic                  d_wr_en,
  output logic [W_ADDR-1:0]     d_addr,
  output logic [W_DATA-1:0]     d_wdata,
  output logic [W_DATA/8-1:0]   d_mask,
  input  logic [W_DATA-1:0]     d_rdata,
  input  logic                  d_busy,
  input  logic                  d_init_done,
  output logic                  gnt_id
);

  localparam int W_MASK = W_DATA / 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Watchdog value at which the ISSUE phase is abandoned
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  // Downstream addresses are word aligned
  localparam logic [W_ADDR-1:0] ADDR_WORD_MASK = {{(W_ADDR-2){1'b1}}, 2'b00};

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [W_ADDR-1:0] addr_q, addr_d;
  logic [W_DATA-1:0] wdata_q, wdata_d;
  logic [W_MASK-1:0] mask_q, mask_d;
  logic [7:0]        wd_q, wd_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic [1:0]        ready_q, ready_d;
  logic [1:0]        done_q, done_d;
  logic              err_q, err_d;
  logic [W_DATA-1:0] rdata_q, rdata_d;
  logic              gid_s;

  // Chooses the requester to serve; last is the previous winner
  function automatic logic pick_grant(input logic [1:0] valid, input logic last);
    logic g;
    case (valid)
      2'b01:   g = 1'b0;
      2'b10:   g = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      2'b11:   g = ~last;
`else
      2'b11:   g = 1'b0;
`endif
      default: g = 1'b0;
    endcase
    return g;
  endfunction

  // Arbitration winner for the current cycle
  always_comb begin
    gid_s = pick_grant(rq_valid, last_q);
  end

  // Transaction sequencer: next-state and next-output computation
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    wd_d    = wd_q;
    rd_en_d = rd_en_q;
    wr_en_d = wr_en_q;
    ready_d = 2'b00;
    done_d  = 2'b00;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (d_init_done && !d_busy && (rq_valid != 2'b00)) begin
          gnt_d   = gid_s;
          wd_d    = 8'd0;
          state_d = S_ISSUE;
          if (gid_s) begin
            ready_d = 2'b10;
            we_d    = rq_we[1];
            addr_d  = rq_addr1 & ADDR_WORD_MASK;
            wdata_d = rq_wdata1;
            mask_d  = rq_mask1;
          end else begin
            ready_d = 2'b01;
            we_d    = rq_we[0];
            addr_d  = rq_addr0 & ADDR_WORD_MASK;
            wdata_d = rq_wdata0;
            mask_d  = rq_mask0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (d_busy) begin
          // Cache accepted the command: release the enable
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          state_d = S_WAIT;
        end else if (wd_q == WD_LAST) begin
          // Cache never responded: abandon with an error completion
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          done_d  = gnt_q ? 2'b10 : 2'b01;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          rd_en_d = ~we_q;
          wr_en_d = we_q;
          wd_d    = wd_q + 8'd1;
        end
      end
      S_WAIT: begin
        if (!d_busy) begin
          if (!we_q) begin
            rdata_d = d_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          done_d  = gnt_q ? 2'b10 : 2'b01;
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: begin
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= {W_ADDR{1'b0}};
      wdata_q <= {W_DATA{1'b0}};
      mask_q  <= {W_MASK{1'b0}};
      wd_q    <= 8'd0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      ready_q <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 1'b0;
      rdata_q <= {W_DATA{1'b0}};
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      wd_q    <= wd_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign rq_ready = ready_q;
  assign rq_done  = done_q;
  assign rq_err   = err_q;
  assign rq_rdata = rdata_q;
  assign d_rd_en  = rd_en_q;
  assign d_wr_en  = wr_en_q;
  assign d_addr   = addr_q;
  assign d_wdata  = wdata_q;
  assign d_mask   = mask_q;
  assign gnt_id   = gnt_q;

endmodule
